// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Holds the loader FSM state encoding and word geometry.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_CNT_LO = 3'd0,
      ST_CNT_HI = 3'd1,
      ST_DATA   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int WORD_BITS  = 8 * WORD_BYTES;
   localparam int IDX_W      = $clog2(WORD_BYTES);

   // States in which the loader takes a byte from the host link.
   function automatic logic is_rx_state(input state_t s);
      return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Packs little-endian payload bytes into a 32-bit word and keeps the running 8-bit payload sum.
// Single-cycle update per accepted byte; o_last flags that the next byte completes the word.
module byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_clear,
   input  logic                 i_byte_vld,
   input  logic [7:0]           i_byte_dat,
   output logic [WORD_BITS-1:0] o_word,
   output logic                 o_last,
   output logic [7:0]           o_csum
);

   logic [IDX_W-1:0]     r_idx;
   logic [WORD_BITS-1:0] r_word;
   logic [7:0]           r_csum;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_idx  <= '0;
         r_word <= '0;
         r_csum <= '0;
      end else if (i_byte_vld) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
               r_word[8*i +: 8] <= i_byte_dat;
            end
         end
         r_csum <= r_csum + i_byte_dat;
         r_idx  <= r_idx + IDX_W'(1);
      end
   end

   assign o_word = r_word;
   assign o_last = (r_idx == IDX_W'(WORD_BYTES - 1));
   assign o_csum = r_csum;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a host byte stream into words, writes them from BASE_ADDR and checks the sum.
// Keeps the core in reset until the image is written and verified; stalls the link during writes.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_WIDTH = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic        core_reset,
   output logic        done,
   output logic        error
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_words_done;
   logic [31:0]          r_addr;

   logic                 w_rx_state;
   logic                 w_acc;
   logic                 w_we;
   logic                 w_core_rst;
   logic                 w_done;
   logic                 w_err;
   logic                 w_clear;
   logic                 w_pack_vld;
   logic [CNT_WIDTH-1:0] w_cnt_hdr;
   logic [CNT_WIDTH-1:0] w_words_inc;
   logic [WORD_BITS-1:0] w_word;
   logic                 w_last;
   logic [7:0]           w_csum;

   assign w_rx_state  = is_rx_state(r_state);
   assign w_acc       = in_valid & w_rx_state & ~reset;
   assign w_cnt_hdr   = CNT_WIDTH'({in_data, r_cnt[7:0]});
   assign w_words_inc = r_words_done + CNT_WIDTH'(1);

   byte_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_clear),
      .i_byte_vld (w_pack_vld),
      .i_byte_dat (in_data),
      .o_word     (w_word),
      .o_last     (w_last),
      .o_csum     (w_csum)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_CNT_LO;
         r_cnt        <= '0;
         r_words_done <= '0;
         r_addr       <= BASE_ADDR;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_CNT_LO && w_acc) begin
            r_cnt[7:0]   <= in_data;
            r_words_done <= '0;
            r_addr       <= BASE_ADDR;
         end
         if (r_state == ST_CNT_HI && w_acc) begin
            r_cnt <= w_cnt_hdr;
         end
         // Address wraps mod 2^32 by design.
         if (r_state == ST_WRITE && mem_ready) begin
            r_addr       <= r_addr + 32'(WORD_BYTES);
            r_words_done <= w_words_inc;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_core_rst  = 1'b1;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_clear     = 1'b0;
      w_pack_vld  = 1'b0;
      case (r_state)
         ST_CNT_LO: begin
            if (w_acc) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_CNT_HI;
            end
         end
         ST_CNT_HI: begin
            if (w_acc) begin
               w_state_nxt = (w_cnt_hdr == '0) ? ST_CSUM : ST_DATA;
            end
         end
         ST_DATA: begin
            w_pack_vld = w_acc;
            if (w_acc && w_last) begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_we = 1'b1;
            if (mem_ready) begin
               w_state_nxt = (w_words_inc == r_cnt) ? ST_CSUM : ST_DATA;
            end
         end
         ST_CSUM: begin
            if (w_acc) begin
               w_state_nxt = (in_data == w_csum) ? ST_DONE : ST_ERROR;
            end
         end
         ST_DONE: begin
            w_core_rst = 1'b0;
            w_done     = 1'b1;
            if (start) begin
               w_state_nxt = ST_CNT_LO;
            end
         end
         ST_ERROR: begin
            w_err = 1'b1;
            if (start) begin
               w_state_nxt = ST_CNT_LO;
            end
         end
         default: begin
            w_state_nxt = ST_CNT_LO;
         end
      endcase
   end

   // Status outputs are forced to their idle values while reset is held.
   assign in_ready   = w_rx_state & ~reset;
   assign mem_we     = w_we & ~reset;
   assign core_reset = w_core_rst | reset;
   assign done       = w_done & ~reset;
   assign error      = w_err & ~reset;
   assign mem_addr   = r_addr;
   assign mem_wdata  = w_word;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are driven byte by byte, expected writes are queued,
// and a negedge monitor compares every memory write request against the queue head.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        core_reset;
   logic        done;
   logic        error;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] frame_q[$];
   int          checks = 0;
   int          errors = 0;
   int          stall_per_write = 0;
   int          stall_cnt = 0;
   int          gap_cycles = 0;

   imem_loader #(.BASE_ADDR(BASE), .CNT_WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .core_reset (core_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory side: optionally hold mem_ready low for stall_per_write cycles of each write.
   initial begin
      mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (mem_we && stall_cnt < stall_per_write) begin
            mem_ready = 1'b0;
            stall_cnt++;
         end else begin
            mem_ready = 1'b1;
            if (!mem_we) stall_cnt = 0;
         end
      end
   end

   // Monitor: every cycle with mem_we high must match the queue head; pop on acceptance.
   always @(negedge clk) begin
      if (!reset && mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%h data=%h required=no write", mem_addr, mem_wdata);
         end else begin
            check("wr_addr", mem_addr, exp_q[0].addr);
            check("wr_data", mem_wdata, exp_q[0].data);
            check("wr_in_ready_low", {31'b0, in_ready}, 32'd0);
            if (mem_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Returns at posedge+1 of the cycle that accepted the byte.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout actual=in_ready stuck low required=accept of %h", b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic gap();
      repeat (gap_cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic corrupt);
      logic [7:0]  csum;
      logic [7:0]  b;
      logic [31:0] w;
      logic [15:0] n;
      csum = 8'h00;
      n = 16'(frame_q.size());
      send_byte(n[7:0]);
      gap();
      send_byte(n[15:8]);
      gap();
      for (int i = 0; i < frame_q.size(); i++) begin
         w = frame_q[i];
         for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            csum = csum + b;
            if (k == 0) exp_q.push_back('{addr: BASE + 32'(4*i), data: w});
            send_byte(b);
            if (k == 3) check("we_latency", {31'b0, mem_we}, 32'd1);
            gap();
         end
      end
      send_byte(corrupt ? csum + 8'h01 : csum);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, BASE);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_core_reset"}, {31'b0, core_reset}, 32'd1);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_error"}, {31'b0, error}, 32'd0);
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_error"}, {31'b0, error}, 32'd0);
      check({tag, "_core_reset"}, {31'b0, core_reset}, 32'd0);
      check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=simulation still running required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("arm_in_ready", {31'b0, in_ready}, 32'd1);
      check("arm_core_reset", {31'b0, core_reset}, 32'd1);

      // 1: single word
      frame_q = '{32'h0001_4097};
      send_frame(1'b0);
      check_done("s1");
      pulse_start();
      check("rearm_done", {31'b0, done}, 32'd0);
      check("rearm_core_reset", {31'b0, core_reset}, 32'd1);
      check("rearm_in_ready", {31'b0, in_ready}, 32'd1);

      // 2: three auipc words
      frame_q = '{32'h0001_4097, 32'h000c_8117, 32'h003f_f197};
      send_frame(1'b0);
      check_done("s2");
      pulse_start();

      // 3: memory stalls and gaps on the link
      stall_per_write = 5;
      gap_cycles = 2;
      send_frame(1'b0);
      check_done("s3");
      stall_per_write = 0;
      gap_cycles = 0;
      pulse_start();

      // 4: bad checksum, sticky error, then recovery
      frame_q = '{32'h0001_4097};
      send_frame(1'b1);
      check("s4_error", {31'b0, error}, 32'd1);
      check("s4_done", {31'b0, done}, 32'd0);
      check("s4_core_reset", {31'b0, core_reset}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("s4_error_sticky", {31'b0, error}, 32'd1);
      pulse_start();
      check("s4_error_clr", {31'b0, error}, 32'd0);
      send_frame(1'b0);
      check_done("s4b");
      pulse_start();

      // 5: empty image
      frame_q.delete();
      send_frame(1'b0);
      check_done("s5");
      pulse_start();

      // 6: reset mid-frame, then a fresh load from BASE
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h97);
      send_byte(8'h40);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("midrst");
      reset = 1'b0;
      @(posedge clk);
      #1;
      frame_q = '{32'hDEAD_BEEF, 32'h1234_5678};
      send_frame(1'b0);
      check_done("s6");

      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
